// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with bursts of up to MAX_BURST writes.
// Optional FIFO_ARB_CNT_EN adds a 16-bit wrapping count of accepted writes (wr_count).
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] din_bus,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_ready,
  output logic                        fifo_wen,
  output logic [DATA_WIDTH-1:0]       fifo_din
`ifdef FIFO_ARB_CNT_EN
  ,
  output logic [15:0]                 wr_count
`endif
);

  localparam int OWN_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [OWN_W-1:0]   owner_r, owner_s;
  logic [OWN_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]   burst_cnt_r, burst_cnt_s;
  logic [OWN_W-1:0]   pick_s;
  logic               pick_vld_s;
  logic               wr_ok_s;

  function automatic logic [OWN_W-1:0] wrap_inc(input logic [OWN_W-1:0] v);
    return (int'(v) == N_REQ - 1) ? {OWN_W{1'b0}} : v + OWN_W'(1);
  endfunction

  // Round-robin search: scan downward so the index closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx_v;
    idx_v      = 0;
    pick_vld_s = 1'b0;
    pick_s     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_v      = (int'(rr_ptr_r) + i) % N_REQ;
      pick_vld_s = pick_vld_s | req[idx_v];
      pick_s     = req[idx_v] ? OWN_W'(idx_v) : pick_s;
    end
  end

  // Next-state and output decode for the IDLE/GRANT machine.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    burst_cnt_s = burst_cnt_r;
    wr_ok_s     = 1'b0;
    fifo_wen    = 1'b0;
    fifo_din    = '0;
    gnt         = '0;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          state_s     = GRANT;
          owner_s     = pick_s;
          burst_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        fifo_din     = din_bus[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
        wr_ok_s      = req[owner_r] & fifo_ready;
        fifo_wen     = wr_ok_s & ~clear;
        gnt[owner_r] = fifo_wen;
        // Release on dropped request or on the write that completes the burst.
        if (!req[owner_r] || (wr_ok_s && (burst_cnt_r == CNT_W'(MAX_BURST - 1)))) begin
          state_s     = IDLE;
          rr_ptr_s    = wrap_inc(owner_r);
          burst_cnt_s = '0;
        end else if (wr_ok_s) begin
          burst_cnt_s = burst_cnt_r + CNT_W'(1);
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset and flush.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_r     <= IDLE;
      owner_r     <= '0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      rr_ptr_r    <= rr_ptr_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

`ifdef FIFO_ARB_CNT_EN
  // Accepted-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_count <= 16'd0;
    end else if (fifo_wen) begin
      wr_count <= wr_count + 16'd1;
    end else begin
      wr_count <= wr_count;
    end
  end
`endif

endmodule
